rc4_ctrl: RTL and testbench
===========================

RC4_CTRL -- requirements
Module: rc4_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the byte-count field.
REQ-002 SHALL have parameter WDOG_LIMIT, default 320: number of LOAD cycles allowed before a timeout.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: request a new session; sampled in IDLE only.
REQ-006 SHALL have port key_in, input, 8 bits: session key byte; captured on an accepted start.
REQ-007 SHALL have port len, input, LEN_W bits: number of bytes to stream; captured on an accepted start.
REQ-008 SHALL have port kg_ready, input, 1 bit: key-generator finish flag (data_rready).
REQ-009 SHALL have port byte_valid, input, 1 bit: upstream byte offered.
REQ-010 SHALL have port byte_ready, output, 1 bit: controller accepts a byte this cycle.
REQ-011 SHALL have port ns, output, 2 bits: phase command to the key generator (00 INIT, 01 KEY_GENE, 10 EN_DE_CODE).
REQ-012 SHALL have port key_init, output, 8 bits: latched key driven to the key generator.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at session end.
REQ-015 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-016 SHALL implement states IDLE, LOAD, SETTLE, STREAM, ABORT and DONE.
REQ-017 SHALL drive ns per state: IDLE=00, LOAD=01, SETTLE=01, STREAM=10, ABORT=10, DONE=00.
REQ-018 In IDLE, start=1 SHALL capture key_in into key_init and len into the remaining counter, clear err, and go to LOAD on the next edge.
REQ-019 start SHALL be ignored in every state except IDLE; key_init and the remaining counter SHALL NOT change outside an accepted start or a byte transfer.
REQ-020 In LOAD, kg_ready=1 SHALL move to SETTLE; SETTLE SHALL last exactly one cycle with ns=01, so the generator copies its table.
REQ-021 From SETTLE, the next state SHALL be STREAM if remaining!=0, else DONE (len=0: no bytes accepted).
REQ-022 byte_ready SHALL be 1 only in STREAM; a transfer occurs when byte_valid && byte_ready.
REQ-023 Each transfer SHALL decrement remaining by 1.
REQ-024 A transfer with remaining==1 SHALL go to DONE; byte_ready SHALL be 0 in DONE.
REQ-025 The remaining counter SHALL never wrap below 0.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 ABORT SHALL last one cycle (ns=10 clears the generator state), then return to IDLE.
REQ-028 A full session with len=N and byte_valid held high SHALL take 1 (LOAD entry) + generator latency + 1 (SETTLE) + N (STREAM) + 1 (DONE) cycles.

Reset
REQ-029 rst=0 SHALL asynchronously force the IDLE state and set ns=00, key_init=0, remaining=0, byte_ready=0, busy=0, done=0, err=0, and the watchdog counter to 0.
REQ-030 rst asserted in any state mid-session SHALL abandon the session with no done pulse; operation SHALL resume on the first edge after release, with start honoured in IDLE.

Configuration
REQ-031 Macro RC4_CTRL_WDOG_EN SHALL compile the LOAD watchdog in or out.
REQ-032 With RC4_CTRL_WDOG_EN defined: a counter SHALL clear on entry to LOAD and increment each LOAD cycle.
REQ-033 With RC4_CTRL_WDOG_EN defined: reaching WDOG_LIMIT with kg_ready=0 SHALL set err=1 and go to ABORT; kg_ready=1 in the same cycle SHALL win and go to SETTLE.
REQ-034 With RC4_CTRL_WDOG_EN undefined: err SHALL be tied to 0, there SHALL be no counter, and LOAD SHALL wait indefinitely; ABORT SHALL then be unreachable.

Verification
REQ-035 start with key_in=0x3C, len=4; kg_ready raised 258 cycles after LOAD entry; byte_valid held 1 -> ns sequence 00,01..01,01(SETTLE),10x4,00; exactly 4 transfers; key_init=0x3C; done=1 for one cycle.
REQ-036 len=0 -> LOAD, SETTLE, DONE directly; byte_ready never 1; done pulses once.
REQ-037 byte_valid toggling 1,0,1,0 during STREAM with len=2 -> remaining goes 2,1,0 only on transfer cycles; DONE follows the second transfer.
REQ-038 start re-asserted during STREAM with key_in=0x55 -> ignored; key_init stays 0x3C.
REQ-039 rst pulled low mid-STREAM -> all outputs 0 immediately, no done pulse; a new start after release runs normally.
REQ-040 With RC4_CTRL_WDOG_EN defined and kg_ready held 0 -> err=1 after 320 LOAD cycles, one ABORT cycle with ns=10, then IDLE; err clears on the next accepted start.

Source files
------------

// File: rtl/rc4_ctrl_if.sv
// rtl/rc4_ctrl_if.sv - session request, generator handshake and byte-stream signals of rc4_ctrl
interface rc4_ctrl_if #(
   parameter int LEN_W = 16
);
   logic             start;
   logic [7:0]       key_in;
   logic [LEN_W-1:0] len;
   logic             kg_ready;
   logic             byte_valid;
   logic             byte_ready;
   logic [1:0]       ns;
   logic [7:0]       key_init;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, key_in, len, kg_ready, byte_valid,
      input  byte_ready, ns, key_init, busy, done, err
   );

   modport slave (
      input  start, key_in, len, kg_ready, byte_valid,
      output byte_ready, ns, key_init, busy, done, err
   );
endinterface

// File: rtl/rc4_ctrl.sv
// rtl/rc4_ctrl.sv - RC4 session controller (LOAD watchdog compiled in by RC4_CTRL_WDOG_EN)
module rc4_ctrl #(
   parameter int LEN_W      = 16,
   parameter int WDOG_LIMIT = 320
) (
   input logic       clk,
   input logic       rst,
   rc4_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_STREAM,
      S_ABORT,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] remaining;
   logic [7:0]       key_q;
   logic             err_q;
   logic             accept;
   logic             xfer;
   logic             timeout;

   assign accept = (state == S_IDLE) && bus.start;
   assign xfer   = (state == S_STREAM) && bus.byte_valid;

`ifdef RC4_CTRL_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

   logic [WDOG_W-1:0] wdog;

   // wdog holds the number of LOAD cycles already spent, so the last allowed cycle sees LIMIT-1
   assign timeout = (state == S_LOAD) && !bus.kg_ready &&
                    (wdog == WDOG_W'(WDOG_LIMIT - 1));

   // LOAD cycle counter, restarted whenever a session is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog <= '0;
      end else if (accept) begin
         wdog <= '0;
      end else if (state == S_LOAD) begin
         wdog <= wdog + 1'b1;
      end
   end

   // sticky timeout flag, cleared only by the next accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= 1'b0;
      end else if (timeout) begin
         err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err_q   = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // session key and byte budget; only a start or a transfer may touch them
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q     <= '0;
         remaining <= '0;
      end else if (accept) begin
         key_q     <= bus.key_in;
         remaining <= bus.len;
      end else if (xfer && (remaining != '0)) begin
         remaining <= remaining - 1'b1;
      end
   end

   // next-state decision
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (bus.kg_ready)  state_nxt = S_SETTLE;
            else if (timeout)  state_nxt = S_ABORT;
         end
         S_SETTLE: begin
            state_nxt = (remaining != '0) ? S_STREAM : S_DONE;
         end
         S_STREAM: begin
            if (bus.byte_valid && (remaining == LEN_W'(1))) state_nxt = S_DONE;
         end
         S_ABORT:  state_nxt = S_IDLE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // per-state outputs; ABORT keeps EN_DE_CODE for one cycle so the generator drops its state
   always_comb begin
      bus.ns         = 2'b00;
      bus.byte_ready = 1'b0;
      bus.done       = 1'b0;
      bus.busy       = (state != S_IDLE);
      case (state)
         S_LOAD, S_SETTLE: bus.ns = 2'b01;
         S_STREAM: begin
            bus.ns         = 2'b10;
            bus.byte_ready = 1'b1;
         end
         S_ABORT:  bus.ns = 2'b10;
         S_DONE:   bus.done = 1'b1;
         default:  bus.ns = 2'b00;
      endcase
   end

   assign bus.key_init = key_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_rc4_ctrl.sv
// tb/tb_rc4_ctrl.sv - scoreboard bench for rc4_ctrl
module tb_rc4_ctrl;

   typedef struct {
      logic [7:0] key;
      int         n;
   } sess_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   xfer_cnt;

   sess_t       sb_q[$];
   logic [13:0] trace[$];
   logic [13:0] exp_trace[$];

   rc4_ctrl_if #(.LEN_W(16)) bus ();

   rc4_ctrl #(.LEN_W(16), .WDOG_LIMIT(320)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: count transfers, pop the expected session on each done pulse
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) xfer_cnt++;
         if (bus.done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_done: got done=1 want no pending session");
            end else begin
               sess_t e;
               e = sb_q.pop_front();
               if (xfer_cnt !== e.n || bus.key_init !== e.key) begin
                  errors++;
                  $display("FAIL sb_session: got xfers %0d key %h want xfers %0d key %h",
                           xfer_cnt, bus.key_init, e.n, e.key);
               end
            end
            xfer_cnt = 0;
         end
      end
   end

   task automatic start_session(input logic [7:0] k, input logic [15:0] n);
      sess_t s;
      s.key = k;
      s.n   = int'(n);
      sb_q.push_back(s);
      xfer_cnt   = 0;
      bus.start  = 1'b1;
      bus.key_in = k;
      bus.len    = n;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.key_in = 8'($urandom);
      bus.len    = 16'($urandom);
   endtask

   task automatic drive_kg(input int lat);
      repeat (lat - 1) @(posedge clk);
      #1 bus.kg_ready = 1'b1;
      @(posedge clk);
      #1 bus.kg_ready = 1'b0;
   endtask

   task automatic capture(input int budget, output int to);
      trace.delete();
      to = 1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         trace.push_back({bus.ns, bus.byte_ready, bus.done, bus.busy, bus.err, dut.remaining[7:0]});
         if (bus.busy === 1'b0) begin
            to = 0;
            break;
         end
      end
   endtask

   task automatic push_exp(input logic [1:0] n, input logic r, input logic d, input logic b,
                           input logic e, input logic [7:0] rem, input int cnt);
      repeat (cnt) exp_trace.push_back({n, r, d, b, e, rem});
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.start = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.ns, bus.byte_ready, bus.busy, bus.done, bus.err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got ns %b rdy %b busy %b done %b err %b want all 0",
                  bus.ns, bus.byte_ready, bus.busy, bus.done, bus.err);
      end
      checks++;
      if (bus.key_init !== 8'h00 || dut.remaining !== 16'h0) begin
         errors++;
         $display("FAIL reset_regs: got key %h rem %h want 00 0000", bus.key_init, dut.remaining);
      end
      bus.start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.ns !== 2'b00) begin
         errors++;
         $display("FAIL reset_release_idle: got busy %b ns %b want 0 00", bus.busy, bus.ns);
      end
   endtask

   task automatic test_basic;
      int to, idx;
      logic [13:0] g, w;
      bus.byte_valid = 1'b1;
      exp_trace.delete();
      push_exp(2'b01, 0, 0, 1, 0, 8'd4, 258);
      push_exp(2'b01, 0, 0, 1, 0, 8'd4, 1);
      for (int i = 0; i < 4; i++) push_exp(2'b10, 1, 0, 1, 0, 8'(4 - i), 1);
      push_exp(2'b00, 0, 1, 1, 0, 8'd0, 1);
      push_exp(2'b00, 0, 0, 0, 0, 8'd0, 1);
      start_session(8'h3C, 16'd4);
      fork
         drive_kg(258);
         capture(1000, to);
      join
      idx = -1; g = '0; w = '0;
      for (int i = 0; i < trace.size() && i < exp_trace.size(); i++)
         if (idx < 0 && trace[i] !== exp_trace[i]) begin idx = i; g = trace[i]; w = exp_trace[i]; end
      checks++;
      if (to != 0 || idx >= 0 || trace.size() != exp_trace.size()) begin
         errors++;
         $display("FAIL trace_basic: got %0d samples diff@%0d %h want %0d samples %h",
                  trace.size(), idx, g, exp_trace.size(), w);
      end
      checks++;
      if (bus.key_init !== 8'h3C) begin
         errors++;
         $display("FAIL basic_key: got %h want 3c", bus.key_init);
      end
   endtask

   task automatic test_len_zero;
      int to, idx;
      logic [13:0] g, w;
      bus.byte_valid = 1'b1;
      exp_trace.delete();
      push_exp(2'b01, 0, 0, 1, 0, 8'd0, 5);
      push_exp(2'b01, 0, 0, 1, 0, 8'd0, 1);
      push_exp(2'b00, 0, 1, 1, 0, 8'd0, 1);
      push_exp(2'b00, 0, 0, 0, 0, 8'd0, 1);
      start_session(8'h9A, 16'd0);
      fork
         drive_kg(5);
         capture(100, to);
      join
      idx = -1; g = '0; w = '0;
      for (int i = 0; i < trace.size() && i < exp_trace.size(); i++)
         if (idx < 0 && trace[i] !== exp_trace[i]) begin idx = i; g = trace[i]; w = exp_trace[i]; end
      checks++;
      if (to != 0 || idx >= 0 || trace.size() != exp_trace.size()) begin
         errors++;
         $display("FAIL trace_len_zero: got %0d samples diff@%0d %h want %0d samples %h",
                  trace.size(), idx, g, exp_trace.size(), w);
      end
   endtask

   task automatic test_valid_toggle;
      int to, idx;
      logic [13:0] g, w;
      bus.byte_valid = 1'b0;
      exp_trace.delete();
      push_exp(2'b01, 0, 0, 1, 0, 8'd2, 3);
      push_exp(2'b01, 0, 0, 1, 0, 8'd2, 1);
      push_exp(2'b10, 1, 0, 1, 0, 8'd2, 1);
      push_exp(2'b10, 1, 0, 1, 0, 8'd1, 2);
      push_exp(2'b00, 0, 1, 1, 0, 8'd0, 1);
      push_exp(2'b00, 0, 0, 0, 0, 8'd0, 1);
      start_session(8'h21, 16'd2);
      fork
         drive_kg(3);
         capture(100, to);
         begin
            repeat (4) @(posedge clk);
            #1 bus.byte_valid = 1'b1;
            @(posedge clk);
            #1 bus.byte_valid = 1'b0;
            @(posedge clk);
            #1 bus.byte_valid = 1'b1;
            @(posedge clk);
            #1 bus.byte_valid = 1'b0;
         end
      join
      idx = -1; g = '0; w = '0;
      for (int i = 0; i < trace.size() && i < exp_trace.size(); i++)
         if (idx < 0 && trace[i] !== exp_trace[i]) begin idx = i; g = trace[i]; w = exp_trace[i]; end
      checks++;
      if (to != 0 || idx >= 0 || trace.size() != exp_trace.size()) begin
         errors++;
         $display("FAIL trace_valid_toggle: got %0d samples diff@%0d %h want %0d samples %h",
                  trace.size(), idx, g, exp_trace.size(), w);
      end
   endtask

   task automatic test_start_ignored;
      bit seen;
      bus.byte_valid = 1'b0;
      start_session(8'h3C, 16'd3);
      fork
         drive_kg(2);
      join_none
      repeat (3) @(posedge clk);
      #1;
      bus.start  = 1'b1;
      bus.key_in = 8'h55;
      bus.len    = 16'd7;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.ns !== 2'b10 || bus.key_init !== 8'h3C || dut.remaining !== 16'd3) begin
         errors++;
         $display("FAIL start_ignored: got ns %b key %h rem %0d want 10 3c 3",
                  bus.ns, bus.key_init, dut.remaining);
      end
      bus.byte_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL start_ignored_done: got no done within 20 cycles want done pulse");
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.key_init !== 8'h3C) begin
         errors++;
         $display("FAIL start_ignored_idle: got busy %b key %h want 0 3c", bus.busy, bus.key_init);
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic test_reset_mid_stream;
      int to, idx;
      logic [13:0] g, w;
      sess_t s;
      bus.byte_valid = 1'b1;
      start_session(8'h77, 16'd5);
      fork
         drive_kg(1);
      join_none
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (bus.ns !== 2'b10 || dut.remaining !== 16'd3) begin
         errors++;
         $display("FAIL rst_pre_stream: got ns %b rem %0d want 10 3", bus.ns, dut.remaining);
      end
      #2 rst = 1'b0;
      sb_q.delete();
      #1;
      checks++;
      if ({bus.ns, bus.key_init, bus.byte_ready, bus.busy, bus.done, bus.err} !== 13'b0 ||
          dut.remaining !== 16'h0) begin
         errors++;
         $display("FAIL rst_async: got ns %b key %h rdy %b busy %b done %b rem %0d want all 0",
                  bus.ns, bus.key_init, bus.byte_ready, bus.busy, bus.done, dut.remaining);
      end
      bus.start  = 1'b1;
      bus.key_in = 8'hA5;
      bus.len    = 16'd2;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_hold_idle: got busy %b want 0", bus.busy);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      s.key = 8'hA5;
      s.n   = 2;
      sb_q.push_back(s);
      xfer_cnt = 0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      exp_trace.delete();
      push_exp(2'b01, 0, 0, 1, 0, 8'd2, 1);
      push_exp(2'b01, 0, 0, 1, 0, 8'd2, 1);
      push_exp(2'b10, 1, 0, 1, 0, 8'd2, 1);
      push_exp(2'b10, 1, 0, 1, 0, 8'd1, 1);
      push_exp(2'b00, 0, 1, 1, 0, 8'd0, 1);
      push_exp(2'b00, 0, 0, 0, 0, 8'd0, 1);
      fork
         drive_kg(1);
         capture(100, to);
      join
      idx = -1; g = '0; w = '0;
      for (int i = 0; i < trace.size() && i < exp_trace.size(); i++)
         if (idx < 0 && trace[i] !== exp_trace[i]) begin idx = i; g = trace[i]; w = exp_trace[i]; end
      checks++;
      if (to != 0 || idx >= 0 || trace.size() != exp_trace.size()) begin
         errors++;
         $display("FAIL trace_after_rst: got %0d samples diff@%0d %h want %0d samples %h",
                  trace.size(), idx, g, exp_trace.size(), w);
      end
   endtask

   task automatic test_watchdog;
      int to, idx;
      logic [13:0] g, w;
      bus.byte_valid = 1'b1;
      exp_trace.delete();
`ifdef RC4_CTRL_WDOG_EN
      push_exp(2'b01, 0, 0, 1, 0, 8'd2, 320);
      push_exp(2'b10, 0, 0, 1, 1, 8'd2, 1);
      push_exp(2'b00, 0, 0, 0, 1, 8'd2, 1);
      start_session(8'hC3, 16'd2);
      void'(sb_q.pop_back());
      capture(600, to);
`else
      push_exp(2'b01, 0, 0, 1, 0, 8'd2, 400);
      push_exp(2'b01, 0, 0, 1, 0, 8'd2, 1);
      push_exp(2'b10, 1, 0, 1, 0, 8'd2, 1);
      push_exp(2'b10, 1, 0, 1, 0, 8'd1, 1);
      push_exp(2'b00, 0, 1, 1, 0, 8'd0, 1);
      push_exp(2'b00, 0, 0, 0, 0, 8'd0, 1);
      start_session(8'hC3, 16'd2);
      fork
         drive_kg(400);
         capture(600, to);
      join
`endif
      idx = -1; g = '0; w = '0;
      for (int i = 0; i < trace.size() && i < exp_trace.size(); i++)
         if (idx < 0 && trace[i] !== exp_trace[i]) begin idx = i; g = trace[i]; w = exp_trace[i]; end
      checks++;
      if (to != 0 || idx >= 0 || trace.size() != exp_trace.size()) begin
         errors++;
         $display("FAIL trace_watchdog: got %0d samples diff@%0d %h want %0d samples %h",
                  trace.size(), idx, g, exp_trace.size(), w);
      end
      start_session(8'h11, 16'd1);
      fork
         drive_kg(1);
      join_none
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0 || bus.ns !== 2'b01) begin
         errors++;
         $display("FAIL wdog_err_clear: got err %b ns %b want 0 01", bus.err, bus.ns);
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      xfer_cnt = 0;
      bus.start = 1'b0;
      bus.key_in = 8'h00;
      bus.len = 16'h0;
      bus.kg_ready = 1'b0;
      bus.byte_valid = 1'b0;
      rst = 1'b0;
      test_reset;
      test_basic;
      test_len_zero;
      test_valid_toggle;
      test_start_ignored;
      test_reset_mid_stream;
      test_watchdog;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_pending: got %0d sessions without done want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
